// File: rtl/ota_bitstream_decoder.sv
// Decimating decoder for the OTA 1-bit PDM stream: boxcar count per window, or a
// second-order CIC when OTA_DEC_CIC2_EN is defined. Words leave on a valid/ready port.
module ota_bitstream_decoder #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned OSR_LOG2 = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             bit_in,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overrun,
    input  logic             clr_ovr,
    output logic             busy
);

`ifdef OTA_DEC_CIC2_EN
    localparam int unsigned ACC_W      = 2 * OSR_LOG2 + 1;
    localparam int unsigned SHIFT      = 2 * OSR_LOG2 - WIDTH;
    localparam int unsigned SETTLE_WIN = 2;
`else
    localparam int unsigned ACC_W      = OSR_LOG2 + 1;
    localparam int unsigned SHIFT      = OSR_LOG2 - WIDTH;
    localparam int unsigned SETTLE_WIN = 1;
`endif
    localparam logic [ACC_W-1:0] SAT = {{(ACC_W - WIDTH){1'b0}}, {WIDTH{1'b1}}};

    typedef enum logic [1:0] {StIdle, StSettle, StAcq} state_t;

    state_t              state_q, state_d;
    logic [OSR_LOG2-1:0] cnt_q, cnt_d;
    logic                settle_q, settle_d;
    logic                win_end, word_ready, run, clear;
    logic [ACC_W-1:0]    raw, shifted;
    logic [WIDTH-1:0]    word;
    logic [WIDTH-1:0]    data_q, data_d;
    logic                valid_q, valid_d, ovr_q, ovr_d;

`ifdef OTA_DEC_CIC2_EN
    logic [ACC_W-1:0] int1_q, int1_d, int2_q, int2_d;
    logic [ACC_W-1:0] dly1_q, dly1_d, dly2_q, dly2_d;
    logic [ACC_W-1:0] int1_sum, int2_sum, comb1;

    // Integrators free-run and wrap; the comb differences stay exact modulo 2^ACC_W.
    assign int1_sum = int1_q + ACC_W'(bit_in);
    assign int2_sum = int2_q + int1_sum;
    assign comb1    = int2_sum - dly1_q;
    assign raw      = comb1 - dly2_q;

    always_comb begin
        int1_d = int1_q;
        int2_d = int2_q;
        dly1_d = dly1_q;
        dly2_d = dly2_q;
        if (clear) begin
            int1_d = '0;
            int2_d = '0;
            dly1_d = '0;
            dly2_d = '0;
        end else if (run) begin
            int1_d = int1_sum;
            int2_d = int2_sum;
            if (win_end) begin
                dly1_d = int2_sum;
                dly2_d = comb1;
            end
        end
    end
`else
    logic [ACC_W-1:0] acc_q, acc_d;

    assign raw = acc_q + ACC_W'(bit_in);

    always_comb begin
        acc_d = acc_q;
        if (clear) begin
            acc_d = '0;
        end else if (run) begin
            acc_d = win_end ? '0 : raw;
        end
    end
`endif

    assign win_end = &cnt_q;
    assign shifted = raw >> SHIFT;
    assign word    = (shifted > SAT) ? {WIDTH{1'b1}} : shifted[WIDTH-1:0];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        settle_d   = settle_q;
        run        = 1'b0;
        clear      = 1'b0;
        word_ready = 1'b0;
        unique case (state_q)
            StIdle: begin
                clear = 1'b1;
                if (ena) state_d = StSettle;
            end
            StSettle, StAcq: begin
                if (!ena) begin
                    clear   = 1'b1;
                    state_d = StIdle;
                end else begin
                    run   = 1'b1;
                    cnt_d = cnt_q + OSR_LOG2'(1);
                    if (win_end) begin
                        if (state_q == StAcq) begin
                            word_ready = 1'b1;
                        end else if (settle_q == 1'(SETTLE_WIN - 1)) begin
                            settle_d = 1'b0;
                            state_d  = StAcq;
                        end else begin
                            settle_d = settle_q + 1'b1;
                        end
                    end
                end
            end
            default: begin
                clear   = 1'b1;
                state_d = StIdle;
            end
        endcase
        if (clear) begin
            cnt_d    = '0;
            settle_d = 1'b0;
        end
    end

    // A new word may replace one being accepted on the same edge; otherwise it is dropped.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        if (valid_q && out_ready) valid_d = 1'b0;
        if (clr_ovr) ovr_d = 1'b0;
        if (word_ready) begin
            if (!valid_q || out_ready) begin
                data_d  = word;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            settle_q <= 1'b0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            ovr_q    <= 1'b0;
`ifdef OTA_DEC_CIC2_EN
            int1_q   <= '0;
            int2_q   <= '0;
            dly1_q   <= '0;
            dly2_q   <= '0;
`else
            acc_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            settle_q <= settle_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            ovr_q    <= ovr_d;
`ifdef OTA_DEC_CIC2_EN
            int1_q   <= int1_d;
            int2_q   <= int2_d;
            dly1_q   <= dly1_d;
            dly2_q   <= dly2_d;
`else
            acc_q    <= acc_d;
`endif
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign overrun   = ovr_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_ota_bitstream_decoder.sv
// Self-checking bench for ota_bitstream_decoder: a window-level reference model is compared
// against the DUT every cycle, plus literal expectations for latency, duty ratios and handshake.
module tb_ota_bitstream_decoder;
    localparam int WIDTH    = 8;
    localparam int OSR_LOG2 = 8;
    localparam int N        = 1 << OSR_LOG2;
`ifdef OTA_DEC_CIC2_EN
    localparam int S = 2;
`else
    localparam int S = 1;
`endif
    localparam int FIRST = (S + 1) * N + 1;
    localparam int MAXW  = (1 << WIDTH) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ena = 1'b0;
    logic bit_in = 1'b0;
    logic out_ready = 1'b0;
    logic clr_ovr = 1'b0;
    logic [WIDTH-1:0] out_data;
    logic out_valid, overrun, busy;

    int n_checks = 0;
    int n_err = 0;
    int pat = 0;
    int ph = 0;
    int density = 50;
    int rdy_pct = 100;

    ota_bitstream_decoder #(.WIDTH(WIDTH), .OSR_LOG2(OSR_LOG2)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .bit_in(bit_in),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .overrun(overrun), .clr_ovr(clr_ovr), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference model: samples of the current run, window bookkeeping by sample count.
    bit m_active = 1'b0;
    int m_nsamp = 0;
    bit hist [2*N];
    int m_data = 0;
    bit m_valid = 1'b0;
    bit m_ovr = 1'b0;

    function automatic int model_word();
        longint raw = 0;
        int s;
`ifdef OTA_DEC_CIC2_EN
        // Triangular weighting over the last two windows (newest sample has weight 1).
        for (int a = 0; a < 2 * N; a++) begin
            s = m_nsamp - 1 - a;
            if (s >= 0 && hist[s % (2 * N)]) raw += (a < N) ? (a + 1) : (2 * N - 1 - a);
        end
        raw = raw >> (2 * OSR_LOG2 - WIDTH);
`else
        for (int a = 0; a < N; a++) begin
            s = m_nsamp - 1 - a;
            if (s >= 0 && hist[s % (2 * N)]) raw += 1;
        end
        raw = raw >> (OSR_LOG2 - WIDTH);
`endif
        if (raw > MAXW) raw = MAXW;
        return int'(raw);
    endfunction

    initial forever begin : model
        bit rdy;
        bit old_valid;
        int w;
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_active = 0; m_nsamp = 0; m_data = 0; m_valid = 0; m_ovr = 0;
        end else begin
            rdy = 0; w = 0; old_valid = m_valid;
            if (!m_active) begin
                if (ena) begin
                    m_active = 1; m_nsamp = 0;
                    foreach (hist[i]) hist[i] = 0;
                end
            end else if (!ena) begin
                m_active = 0;
            end else begin
                hist[m_nsamp % (2 * N)] = bit_in;
                m_nsamp++;
                if (m_nsamp % N == 0 && m_nsamp / N > S) begin
                    rdy = 1; w = model_word();
                end
            end
            if (old_valid && out_ready) m_valid = 0;
            if (clr_ovr) m_ovr = 0;
            if (rdy) begin
                if (!old_valid || out_ready) begin
                    m_data = w; m_valid = 1;
                end else begin
                    m_ovr = 1;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    initial forever begin : compare
        @(negedge clk);
        if (rst_n) begin
            check("out_data", 32'(out_data), m_data);
            check("out_valid", 32'(out_valid), 32'(m_valid));
            check("overrun", 32'(overrun), 32'(m_ovr));
            check("busy", 32'(busy), 32'(m_active));
        end
    end

    task automatic step();
        @(negedge clk);
        ph++;
        case (pat)
            0: bit_in = 1'b0;
            1: bit_in = 1'b1;
            2: bit_in = (ph % 2 == 0);
            3: bit_in = (ph % 4 == 0);
            4: bit_in = (ph % 4 != 3);
            default: bit_in = ($urandom_range(0, 99) < density);
        endcase
    endtask

    task automatic wait_valid(input int max, output int cyc);
        cyc = 0;
        do begin
            step();
            cyc++;
        end while (!out_valid && cyc < max);
        if (!out_valid) begin
            n_checks++;
            n_err++;
            $display("FAIL wait_valid: no out_valid within %0d cycles", max);
        end
    endtask

    task automatic restart(input int p);
        ena = 1'b0;
        step();
        step();
        pat = p;
        ph = 0;
        ena = 1'b1;
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int cyc;
        repeat (3) @(negedge clk);
        check("reset_data", 32'(out_data), 0);
        check("reset_valid", 32'(out_valid), 0);
        check("reset_ovr", 32'(overrun), 0);
        check("reset_busy", 32'(busy), 0);
        rst_n = 1'b1;

        out_ready = 1'b1;
        restart(1);
        wait_valid(FIRST + 10, cyc);
        check("const1_latency", cyc, FIRST);
        check("const1_data", 32'(out_data), MAXW);
        wait_valid(N + 10, cyc);
        check("const1_period", cyc, N);
        check("const1_data2", 32'(out_data), MAXW);

        restart(0);
        wait_valid(FIRST + 10, cyc);
        check("const0_latency", cyc, FIRST);
        check("const0_data", 32'(out_data), 0);
        check("const0_ovr", 32'(overrun), 0);

        restart(2);
        wait_valid(FIRST + 10, cyc);
        check("duty_10", 32'(out_data), 128);
        restart(3);
        wait_valid(FIRST + 10, cyc);
        check("duty_1000", 32'(out_data), 64);
        restart(4);
        wait_valid(FIRST + 10, cyc);
        check("duty_1110", 32'(out_data), 192);

        // Backpressure: hold the first word while later windows are dropped.
        restart(2);
        out_ready = 1'b0;
        wait_valid(FIRST + 10, cyc);
        check("bp_first", 32'(out_data), 128);
        repeat (3 * N) step();
        check("bp_valid", 32'(out_valid), 1);
        check("bp_data", 32'(out_data), 128);
        check("bp_ovr", 32'(overrun), 1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("bp_accept_valid", 32'(out_valid), 0);
        check("bp_ovr_sticky", 32'(overrun), 1);
        clr_ovr = 1'b1;
        step();
        clr_ovr = 1'b0;
        check("bp_ovr_clr", 32'(overrun), 0);
        wait_valid(N + 10, cyc);
        repeat (N - 1) step();
        out_ready = 1'b1;
        step();
        check("same_edge_valid", 32'(out_valid), 1);
        check("same_edge_ovr", 32'(overrun), 0);

        // Drop enable 100 samples into an ACQ window.
        restart(2);
        wait_valid(FIRST + 10, cyc);
        repeat (100) step();
        ena = 1'b0;
        step();
        check("drop_busy", 32'(busy), 0);
        repeat (9) step();
        check("drop_no_word", 32'(out_valid), 0);
        ena = 1'b1;
        wait_valid(FIRST + 10, cyc);
        check("reenable_latency", cyc, FIRST);

        // Asynchronous reset with a held word and overrun pending.
        restart(2);
        out_ready = 1'b0;
        wait_valid(FIRST + 10, cyc);
        repeat (N) step();
        check("pre_reset_ovr", 32'(overrun), 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_data", 32'(out_data), 0);
        check("async_rst_valid", 32'(out_valid), 0);
        check("async_rst_ovr", 32'(overrun), 0);
        ena = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic checked against the model every cycle.
        pat = 5;
        ena = 1'b1;
        for (int i = 0; i < 8000; i++) begin
            if (i % 700 == 0) density = $urandom_range(0, 100);
            if (i % 600 == 0) rdy_pct = $urandom_range(0, 2) * 50;
            out_ready = ($urandom_range(0, 99) < rdy_pct);
            clr_ovr = ($urandom_range(0, 49) == 0);
            if (i == 3000 || $urandom_range(0, 1999) == 0) ena = 1'b0;
            else if (!ena && $urandom_range(0, 3) == 0) ena = 1'b1;
            step();
        end
        clr_ovr = 1'b0;
        repeat (4) step();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
